// File: rtl/hazard_forward_ctrl_if.sv
// Bundle between ID-stage decode and the hazard/forwarding controller.
// There is no valid/ready pair here: id_valid qualifies the ID slot and has no
// ready. Backpressure toward IF/ID is stall_id, and pipe_hold freezes everything.
// dbg_*_slot expose the internal slots as {valid, rd[4:0], reg_write, mem_read}.
interface hazard_forward_ctrl_if;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic [4:0] id_rd;
  logic       id_reg_write;
  logic       id_mem_read;
  logic       ex_flush;
  logic       pipe_hold;
  logic [1:0] forward_a;
  logic [1:0] forward_b;
  logic       stall_id;
  logic       id_ex_bubble;
  logic [7:0] dbg_ex_slot;
  logic [7:0] dbg_mem_slot;
  logic [7:0] dbg_wb_slot;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_reg_write, id_mem_read, ex_flush, pipe_hold,
    input  forward_a, forward_b, stall_id, id_ex_bubble,
           dbg_ex_slot, dbg_mem_slot, dbg_wb_slot
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_reg_write, id_mem_read, ex_flush, pipe_hold,
    output forward_a, forward_b, stall_id, id_ex_bubble,
           dbg_ex_slot, dbg_mem_slot, dbg_wb_slot
  );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// Hazard controller for the 5-stage RV32 core: tracks in-flight destination
// metadata through ex/mem/wb slots, registers EX-stage forward selects and
// raises load-use stall / ID-EX bubble controls.
module hazard_forward_ctrl (
  input logic                 clk,
  input logic                 rst_n,
  hazard_forward_ctrl_if.slave bus
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } slot_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_EX  = 2'b10;

  slot_t      ex_q, mem_q, wb_q;
  logic [1:0] fwd_a_q, fwd_b_q;
  logic [1:0] fwd_a_d, fwd_b_d;
  logic       ex_match_a, ex_match_b, mem_match_a, mem_match_b;
  logic       load_use, bubble, stall;

  // Match ID sources against the ex/mem slots, pick the youngest producer and
  // detect a load in ex feeding ID. A flush outranks a load-use stall.
  always_comb begin
    ex_match_a  = 1'b0;
    ex_match_b  = 1'b0;
    mem_match_a = 1'b0;
    mem_match_b = 1'b0;
    fwd_a_d     = FWD_RF;
    fwd_b_d     = FWD_RF;
    load_use    = 1'b0;
    bubble      = 1'b0;
    stall       = 1'b0;

    ex_match_a  = ex_q.valid & ex_q.reg_write & (ex_q.rd != 5'd0) &
                  (ex_q.rd == bus.id_rs1) & bus.id_uses_rs1 & bus.id_valid;
    ex_match_b  = ex_q.valid & ex_q.reg_write & (ex_q.rd != 5'd0) &
                  (ex_q.rd == bus.id_rs2) & bus.id_uses_rs2 & bus.id_valid;
    mem_match_a = mem_q.valid & mem_q.reg_write & (mem_q.rd != 5'd0) &
                  (mem_q.rd == bus.id_rs1) & bus.id_uses_rs1 & bus.id_valid;
    mem_match_b = mem_q.valid & mem_q.reg_write & (mem_q.rd != 5'd0) &
                  (mem_q.rd == bus.id_rs2) & bus.id_uses_rs2 & bus.id_valid;

    if (ex_match_a)       fwd_a_d = FWD_EX;
    else if (mem_match_a) fwd_a_d = FWD_MEM;
    if (ex_match_b)       fwd_b_d = FWD_EX;
    else if (mem_match_b) fwd_b_d = FWD_MEM;

    load_use = ex_q.mem_read & (ex_match_a | ex_match_b);
    // rst_n gating keeps both controls quiet while reset is asserted.
    stall    = load_use & ~bus.ex_flush & ~bus.pipe_hold & rst_n;
    bubble   = (load_use | bus.ex_flush) & ~bus.pipe_hold & rst_n;
  end

  // Advance the slots and forward registers unless the pipeline is frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else if (!bus.pipe_hold) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (bubble) begin
        ex_q    <= '0;
        fwd_a_q <= FWD_RF;
        fwd_b_q <= FWD_RF;
      end else begin
        ex_q    <= '{valid: bus.id_valid, rd: bus.id_rd,
                     reg_write: bus.id_reg_write, mem_read: bus.id_mem_read};
        fwd_a_q <= fwd_a_d;
        fwd_b_q <= fwd_b_d;
      end
    end
  end

  assign bus.forward_a    = fwd_a_q;
  assign bus.forward_b    = fwd_b_q;
  assign bus.stall_id     = stall;
  assign bus.id_ex_bubble = bubble;
  assign bus.dbg_ex_slot  = ex_q;
  assign bus.dbg_mem_slot = mem_q;
  assign bus.dbg_wb_slot  = wb_q;

endmodule
